// File: rtl/prog_loader_pkg.sv
// Shared types and limits for the program loader that boots risc_cpu from a byte stream.
package prog_loader_pkg;

  localparam int MEM_DEPTH = 32;
  localparam int MAX_LEN   = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_t;

  // A frame length is usable only if it is non-empty and fits the CPU memory.
  function automatic logic len_ok(input int unsigned len);
    return (len >= 1) && (len <= MAX_LEN) && (len <= MEM_DEPTH);
  endfunction

endpackage

// File: rtl/prog_loader_timeout.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags the TIMEOUT-th one.
module loader_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Expire fires on the idle cycle that would bring the count to TIMEOUT.
  assign expire = enable && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Receives a LEN/DATA/CSUM framed program, writes it into risc_cpu memory and
// releases the CPU from reset only once the checksum matches.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] sum;
  logic              accept;
  logic              start_ok;
  logic              last_byte;
  logic              tmo_clear;
  logic              tmo_en;
  logic              tmo_expire;

  assign accept    = s_valid && s_ready;
  assign start_ok  = start && (state == S_IDLE || state == S_RUN || state == S_ERR);
  assign last_byte = (idx == ADDR_W'(len_q - 1'b1));
  assign tmo_clear = accept || start_ok;
  assign tmo_en    = s_ready && !accept;
  assign busy      = s_ready;

  loader_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tmo_clear),
    .enable(tmo_en),
    .expire(tmo_expire)
  );

  // s_ready is kept in step with the state so it is high exactly in LEN/DATA/CSUM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len_q     <= '0;
      idx       <= '0;
      sum       <= '0;
      s_ready   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_wr <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE, S_RUN, S_ERR: begin
          if (start) begin
            state   <= S_LEN;
            cpu_rst <= 1'b1;
            err     <= 1'b0;
            sum     <= '0;
            idx     <= '0;
            s_ready <= 1'b1;
          end
        end
        S_LEN: begin
          if (accept) begin
            if (len_ok(32'(s_data))) begin
              len_q <= s_data[ADDR_W:0];
              state <= S_DATA;
            end else begin
              state   <= S_ERR;
              err     <= 1'b1;
              s_ready <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            mem_wr    <= 1'b1;
            mem_addr  <= idx;
            mem_wdata <= s_data;
            sum       <= sum + s_data;
            idx       <= idx + 1'b1;
            if (last_byte) begin
              state <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (accept) begin
            s_ready <= 1'b0;
            if (s_data == sum) begin
              state   <= S_RUN;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          s_ready <= 1'b0;
        end
      endcase
      // Expiry only happens on a cycle with no accepted byte, so it safely overrides the case.
      if (tmo_expire) begin
        state   <= S_ERR;
        err     <= 1'b1;
        s_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a frame-level model queues expected writes and outcomes,
// and a negedge monitor pops and compares them as the DUT produces them.
module tb_prog_loader;

  localparam int TMO = 16;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready;
  logic       mem_wr;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_rst;
  logic       busy;
  logic       done;
  logic       err;

  int  checks = 0;
  int  failures = 0;
  wr_t wr_q[$];
  bit  out_q[$];
  wr_t exp_wr;
  logic done_prev;
  logic err_prev;

  prog_loader #(
    .ADDR_W (5),
    .DATA_W (8),
    .TIMEOUT(TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic popOutcome(input bit actual);
    if (out_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected_outcome actual=%0d required=none at %0t", actual, $time);
    end else begin
      checkOutput("outcome_done1_err0", 32'(actual), 32'(out_q.pop_front()));
    end
  endtask

  // Monitor: every write, done pulse and err rising edge must match the head of its queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_prev <= 1'b0;
      err_prev  <= 1'b0;
    end else begin
      if (mem_wr) begin
        if (wr_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_write actual=%0h@%0h required=none", mem_wdata, mem_addr);
        end else begin
          exp_wr = wr_q.pop_front();
          checkOutput("mem_addr", 32'(mem_addr), 32'(exp_wr.addr));
          checkOutput("mem_wdata", 32'(mem_wdata), 32'(exp_wr.data));
        end
      end
      if (done) begin
        checkOutput("done_one_cycle", 32'(done_prev), 0);
        checkOutput("cpu_rst_at_done", 32'(cpu_rst), 0);
        popOutcome(1'b1);
      end
      if (err && !err_prev) begin
        checkOutput("cpu_rst_at_err", 32'(cpu_rst), 1);
        popOutcome(1'b0);
      end
      done_prev <= done;
      err_prev  <= err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startFrame(input bit with_valid, input logic [7:0] b0);
    start = 1'b1;
    if (with_valid) begin
      s_valid = 1'b1;
      s_data  = b0;
    end
    tick();
    start   = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap, input bit inject_start);
    bit rdy;
    bit ok;
    s_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      start = inject_start && (g == 0);
      tick();
      start = 1'b0;
    end
    s_valid = 1'b1;
    s_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rdy = s_ready;
      tick();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    s_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL handshake_timeout actual=not_accepted required=accepted byte=%0h", b);
    end
  endtask

  // Frame-level model: valid LEN gives LEN writes then done/err by checksum; bad LEN gives err only.
  task automatic applyStimulus(input logic [7:0] frame[$], input int gap_lo, input int gap_hi,
                               input bit with_valid, input bit inject);
    int len;
    int sum;
    len = int'(frame[0]);
    startFrame(with_valid, frame[0]);
    if (len == 0 || len > 32) begin
      out_q.push_back(1'b0);
      sendByte(frame[0], $urandom_range(gap_hi, gap_lo), 1'b0);
    end else begin
      sum = 0;
      for (int i = 1; i <= len; i++) begin
        wr_q.push_back('{addr: 5'(i - 1), data: frame[i]});
        sum = (sum + int'(frame[i])) % 256;
      end
      out_q.push_back(int'(frame[len + 1]) == sum);
      for (int i = 0; i < len + 2; i++) begin
        sendByte(frame[i], $urandom_range(gap_hi, gap_lo), inject && ($urandom_range(0, 3) == 0));
      end
    end
    repeat (4) tick();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] f[$];
    int len;
    int sum;

    // Reset values, and stream data ignored without a start.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cpu_rst", 32'(cpu_rst), 1);
    checkOutput("rst_s_ready", 32'(s_ready), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_err", 32'(err), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_mem_wr", 32'(mem_wr), 0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 0);
    rst_n = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h05;
    repeat (5) tick();
    s_valid = 1'b0;
    checkOutput("idle_s_ready", 32'(s_ready), 0);
    checkOutput("idle_cpu_rst", 32'(cpu_rst), 1);

    // Good frame, first byte presented together with start.
    f = '{8'h03, 8'h01, 8'h02, 8'h04, 8'h07};
    applyStimulus(f, 0, 0, 1'b1, 1'b0);
    checkOutput("run_cpu_rst", 32'(cpu_rst), 0);
    checkOutput("run_s_ready", 32'(s_ready), 0);
    checkOutput("run_err", 32'(err), 0);

    // Bad checksum.
    f = '{8'h02, 8'h10, 8'h20, 8'h31};
    applyStimulus(f, 0, 1, 1'b0, 1'b0);
    checkOutput("csum_err", 32'(err), 1);
    checkOutput("csum_cpu_rst", 32'(cpu_rst), 1);

    // Next start clears err; LEN=00 then LEN=21h fail at once.
    startFrame(1'b0, 8'h00);
    checkOutput("start_clears_err", 32'(err), 0);
    checkOutput("start_busy", 32'(busy), 1);
    out_q.push_back(1'b0);
    sendByte(8'h00, 0, 1'b0);
    checkOutput("len0_err", 32'(err), 1);
    repeat (2) tick();
    f = '{8'h21};
    applyStimulus(f, 0, 0, 1'b0, 1'b0);
    checkOutput("len21_err", 32'(err), 1);

    // Timeout after TMO idle cycles inside a frame.
    startFrame(1'b0, 8'h00);
    wr_q.push_back('{addr: 5'd0, data: 8'hAA});
    out_q.push_back(1'b0);
    sendByte(8'h02, 0, 1'b0);
    sendByte(8'hAA, 0, 1'b0);
    repeat (TMO - 1) @(posedge clk);
    @(negedge clk);
    checkOutput("tmo_not_yet", 32'(err), 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("tmo_err", 32'(err), 1);
    checkOutput("tmo_s_ready", 32'(s_ready), 0);
    tick();

    // Gaps of TMO-1 must still succeed.
    f = '{8'h02, 8'h11, 8'h22, 8'h33};
    applyStimulus(f, TMO - 1, TMO - 1, 1'b0, 1'b0);
    checkOutput("gap_ok_cpu_rst", 32'(cpu_rst), 0);

    // Full 32-byte image.
    f = '{8'h20};
    for (int i = 0; i < 32; i++) f.push_back(8'hFF);
    f.push_back(8'hE0);
    applyStimulus(f, 0, 0, 1'b0, 1'b0);
    checkOutput("full_cpu_rst", 32'(cpu_rst), 0);

    // Reset in the middle of a reload.
    startFrame(1'b0, 8'h00);
    wr_q.push_back('{addr: 5'd0, data: 8'h10});
    wr_q.push_back('{addr: 5'd1, data: 8'h20});
    sendByte(8'h03, 0, 1'b0);
    sendByte(8'h10, 0, 1'b0);
    sendByte(8'h20, 0, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_cpu_rst", 32'(cpu_rst), 1);
    checkOutput("midrst_s_ready", 32'(s_ready), 0);
    checkOutput("midrst_mem_addr", 32'(mem_addr), 0);
    checkOutput("midrst_mem_wdata", 32'(mem_wdata), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized frames with occasional bad length, bad checksum and stray starts.
    for (int n = 0; n < 24; n++) begin
      f = {};
      if ($urandom_range(0, 7) == 0) begin
        f.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(33, 255)));
      end else begin
        len = $urandom_range(1, 32);
        f.push_back(8'(len));
        sum = 0;
        for (int i = 0; i < len; i++) begin
          f.push_back(8'($urandom_range(0, 255)));
          sum = (sum + int'(f[i + 1])) % 256;
        end
        if ($urandom_range(0, 4) == 0) sum = (sum + $urandom_range(1, 255)) % 256;
        f.push_back(8'(sum));
      end
      applyStimulus(f, 0, 3, 1'($urandom_range(0, 1)), 1'b1);
    end

    repeat (5) tick();
    checkOutput("writes_drained", 32'(wr_q.size()), 0);
    checkOutput("outcomes_drained", 32'(out_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
